// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window, byte FIFO, baud-rate serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rw,
  input  logic [31:0] ain,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           tx_next;
  logic           full;
  logic           empty;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           baud_done;
  logic [3:0]     count4;
  logic [31:0]    status;

`ifdef UART_TX_PARITY_EN
  logic           parity_q;
`endif

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE) || !empty;

  // A CPU write to TXDATA is a one-cycle push request with no back-pressure:
  // it is taken when a slot is free or a pop frees one on the same edge, else dropped.
  assign push_req = rw && (ain == BASE_ADDR);
  assign pop      = (state == IDLE) && !empty;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) state_next = START;
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_done && (bit_idx == 3'd7)) state_next = PARITY_EN ? PARITY : STOP;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (baud_done) state_next = STOP;
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (baud_done) state_next = IDLE;
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_next;
      if (state == IDLE || baud_done) baud <= '0;
      else                            baud <= baud + BW'(1);
      if (state == START)                  bit_idx <= '0;
      else if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
      if (pop)                             shift <= mem[rd_ptr];
      else if (state == DATA && baud_done) shift <= {1'b0, shift[7:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   parity_q <= 1'b0;
    else if (pop) parity_q <= ^mem[rd_ptr];
  end
`endif

  assign count4 = 4'(count);
  assign status = {24'b0, count4, PARITY_EN, busy, empty, full};

  always_comb begin
    dout = '0;
    if (ain == BASE_ADDR + 32'd4) dout = status;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register decode, frame timing, FIFO overflow,
// push-during-pop while full, and asynchronous reset mid-frame.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] STAT  = BASE + 32'd4;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PAR_BIT    = 32'h8;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PAR_BIT    = 32'h0;
`endif
  localparam int          FRAME = CPB * FRAME_BITS;

  logic        clock;
  logic        reset;
  logic        rw;
  logic [31:0] ain;
  logic [31:0] din;
  logic [31:0] dout;
  logic        tx;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rx_count = 0;
  bit          rx_en = 1'b0;
  logic [7:0]  exp_q[$];

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rw    (rw),
    .ain   (ain),
    .din   (din),
    .dout  (dout),
    .tx    (tx),
    .busy  (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    rw  = 1'b1;
    ain = addr;
    din = data;
    @(posedge clock);
    @(negedge clock);
    rw  = 1'b0;
    ain = STAT;
    din = '0;
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  // scoreboard: decode the line at mid-bit and compare against exp_q
  initial begin : rx_mon
    logic [7:0] d;
    forever begin
      @(negedge clock);
      if (rx_en && reset && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        check("rx_start", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clock);
        check("rx_parity", {31'b0, tx}, {31'b0, ^d});
`endif
        repeat (CPB) @(negedge clock);
        check("rx_stop", {31'b0, tx}, 32'h1);
        rx_count++;
        if (exp_q.size() > 0) check("rx_data", {24'b0, d}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lows;
    int exp_frames;
    logic [7:0] ovf_bytes [5];
    logic [7:0] pp_bytes [5];
    ovf_bytes = '{8'h31, 8'hC4, 8'h7E, 8'h02, 8'h99};
    pp_bytes  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    exp_frames = 0;

    reset = 1'b0;
    rw    = 1'b0;
    ain   = STAT;
    din   = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_status", dout, 32'h2 | PAR_BIT);
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    #1;

    // decode: TXDATA and out-of-window reads are 0; writes outside TXDATA are ignored
    ain = BASE;
    #1 check("rd_txdata", dout, 32'h0);
    ain = BASE + 32'd8;
    #1 check("rd_other", dout, 32'h0);
    ain = STAT;
    write_reg(STAT, 32'h0000_00FF);
    check("wr_status_ignored", dout, 32'h2 | PAR_BIT);
    write_reg(BASE + 32'd8, 32'h0000_0055);
    check("wr_other_ignored", {31'b0, busy}, 32'h0);

    // single frame timing for 0xA5 (upper din bits ignored)
    rx_en = 1'b1;
    exp_q.push_back(8'hA5);
    exp_frames++;
    write_reg(BASE, 32'hFFFF_FFA5);
    check("lat_edge0_tx", {31'b0, tx}, 32'h1);
    @(negedge clock);
    #1 check("lat_edge1_tx", {31'b0, tx}, 32'h1);
    @(negedge clock);
    #1 check("lat_edge2_tx", {31'b0, tx}, 32'h0);
    repeat (FRAME - 2) @(negedge clock);
    #1;
    check("frame_last_busy", {31'b0, busy}, 32'h1);
    check("frame_last_tx", {31'b0, tx}, 32'h1);
    @(negedge clock);
    #1 check("frame_end_busy", {31'b0, busy}, 32'h0);
    wait_idle(50);

    // overflow: five consecutive writes fill the FIFO after one pop; the sixth is dropped
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ovf_bytes[i]);
      write_reg(BASE, {24'b0, ovf_bytes[i]});
    end
    exp_frames += 5;
    check("ovf_status_full", dout, 32'h45 | PAR_BIT);
    write_reg(BASE, 32'h0000_00EE);
    check("ovf_status_drop", dout, 32'h45 | PAR_BIT);
    wait_idle(6 * FRAME);
    check("ovf_rx_count", rx_count, exp_frames);

    // push in the cycle the FSM pops from a full FIFO
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pp_bytes[i]);
      write_reg(BASE, {24'b0, pp_bytes[i]});
    end
    exp_q.push_back(8'h6B);
    exp_frames += 6;
    repeat (FRAME - 4) @(negedge clock);
    #1 check("pp_status_before", dout, 32'h45 | PAR_BIT);
    @(negedge clock);
    write_reg(BASE, 32'h0000_006B);
    check("pp_status_after", dout, 32'h45 | PAR_BIT);
    wait_idle(7 * FRAME);
    check("pp_rx_count", rx_count, exp_frames);

`ifdef UART_TX_PARITY_EN
    exp_q.push_back(8'h07);
    exp_frames++;
    write_reg(BASE, 32'h0000_0007);
    wait_idle(2 * FRAME);
    check("par_rx_count", rx_count, exp_frames);
`endif

    // asynchronous reset during data bit 3 of 0x37, with 0x11 still queued
    rx_en = 1'b0;
    write_reg(BASE, 32'h0000_0037);
    write_reg(BASE, 32'h0000_0011);
    repeat (73) @(negedge clock);
    #1 check("mid_bit3_tx", {31'b0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'h1);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    check("async_rst_status", dout, 32'h2 | PAR_BIT);
    @(negedge clock);
    reset = 1'b1;
    #1 check("post_rst_status", dout, 32'h2 | PAR_BIT);
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("post_rst_quiet", lows, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("rx_total", rx_count, exp_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped 8N1 UART transmitter on the CPU data port, alongside the memory block. It decodes its own address window from the same rw/ain/din/dout signals the memory block uses. Writes queue bytes into a small FIFO. A baud-rate FSM serialises the queued bytes LSB-first onto tx.

Parameters:
BASE_ADDR, 32'h0001_0000, word-aligned base of the 2-register window
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2
FIFO_DEPTH, 4, TX FIFO entries; power of 2, >= 2

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
rw  input  1  1 = write, 0 = read (same encoding as memory block)
ain  input  32  byte address from CPU data port
din  input  32  write data from CPU
dout  output  32  read data to CPU, combinational from ain
tx  output  1  serial line, idle high
busy  output  1  1 while a frame is on the line or FIFO non-empty

Behaviour:
- Register map:
  - BASE_ADDR+0 TXDATA (write only; reads return 0).
  - BASE_ADDR+4 STATUS (read only; writes ignored).
  - Any other address: dout = 0, writes ignored.
- STATUS layout:
  - bit0 full, bit1 empty, bit2 busy, bit3 parity_en.
  - bits[7:4] = FIFO count, zero-extended/truncated to 4 bits.
  - All other bits 0.
- dout: pure combinational decode of ain and current state. No read side effects.
- Push:
  - Occurs when rw=1 and ain==BASE_ADDR at a rising edge.
  - Stores din[7:0]; din[31:8] are ignored.
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise dropped silently; FIFO contents unchanged.
- Pop: occurs on the cycle the FSM leaves IDLE.
- FIFO count = count + push - pop. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, clear baud counter, enter START next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles. Then shift right and increment index; after index 7, go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle when the FIFO is non-empty. Inter-frame gap = stop bit + 1 clock.
- Latency: push at edge N → tx falls after edge N+2 (FIFO register, then IDLE pop, then START).
- Baud counter: counts 0..CLKS_PER_BIT-1; the state/bit advance happens when it reaches CLKS_PER_BIT-1.
- busy = (state != IDLE) | !empty.
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, FIFO pointers and count = 0, baud counter = 0, shift = 0.
  - busy=0; dout reflects empty=1.
- Reset mid-frame: line returns high immediately; the partial frame is abandoned and FIFO contents are discarded.
- Simultaneous push while full with pop in the same cycle: accepted; count stays FIFO_DEPTH.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - STATUS bit3 = 1.
  - Frame length = 11 bits.
- Undefined:
  - No PARITY state; STATUS bit3 = 0.
  - Frame length = 10 bits.

Test Plan:
- Reset then read BASE+4 -> dout=32'h0000_0002, tx=1, busy=0.
- Write 32'hFFFF_FFA5 to BASE+0, CLKS_PER_BIT=16:
  - tx low 2 cycles after the write edge.
  - Bits sampled mid-bit = 0,1,0,1,0,0,1,0,1, then stop=1.
  - Frame length 160 cycles; busy falls after the stop bit.
- Write 6 bytes in consecutive cycles with FIFO_DEPTH=4:
  - First pop frees one slot, so bytes 1-5 are transmitted back-to-back and byte 6 is dropped.
  - STATUS shows full=1 and count=4 just before the 6th write.
  - Line output equals bytes 1-5 in order.
- Push on the same cycle as a pop with FIFO full -> count remains 4, byte accepted and later transmitted.
- Assert reset mid DATA bit 3 -> tx=1 asynchronously, STATUS=32'h2 after release, no further frames.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit=1, frame 176 cycles, STATUS bit3=1.
